cp0_int_ctrl: RTL and testbench

- Interrupt controller between the Bridge-attached interrupt sources (Timer0, Timer1, external interrupt generator, …) and the CP0 HWInt[5:0] input.
- Latches edge-type requests, masks and prioritises all sources, and presents the result to CP0.
- Runs a claim/end-of-interrupt handshake with the handler over a small Bridge-mapped register window, so one source is in service at a time.

---
 rtl/cp0_int_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cp0_int_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl
// Interrupt controller between Bridge-attached interrupt sources and the
// CP0 HWInt[5:0] input. Edge-type sources are latched, level-type sources
// are passed through live. All sources are masked by ENABLE and reduced by
// a fixed-priority encoder (bit 0 highest). A claim / end-of-interrupt
// handshake over a four-word register window keeps one source in service
// at a time; while a source is in service hw_int is held at 0.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   src_irq  raw device requests, synchronous to clk
//   rd_en    Bridge read strobe for this window
//   wr_en    Bridge write strobe for this window
//   addr     word offset: 0 ENABLE, 1 PENDING, 2 CLAIM, 3 EOI
//   wdata    write data
//   rdata    combinational read data for the current addr
//   hw_int   interrupt lines to CP0 HWInt (unused bits driven 0)
//   busy     1 while a source is in service
module cp0_int_ctrl #(
    parameter int               N_SRC     = 6,
    parameter logic [5:0]       EDGE_MASK = 6'b000011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [5:0]       hw_int,
    output logic             busy
);

    typedef enum logic {
        IDLE_ST    = 1'b0,
        SERVICE_ST = 1'b1
    } state_t;

    localparam logic [1:0] A_ENABLE  = 2'd0;
    localparam logic [1:0] A_PENDING = 2'd1;
    localparam logic [1:0] A_CLAIM   = 2'd2;
    localparam logic [1:0] A_EOI     = 2'd3;

    localparam logic [N_SRC-1:0] EDGE_S = EDGE_MASK[N_SRC-1:0];

    // Lowest set index wins; returns 0 for an empty vector (caller checks valid).
    function automatic logic [2:0] prio_id(input logic [N_SRC-1:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = 3'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    state_t             state_r;
    logic [N_SRC-1:0]   enable_r;
    logic [N_SRC-1:0]   latch_r;
    logic [N_SRC-1:0]   prev_r;
    logic [2:0]         in_service_id_r;

    logic [N_SRC-1:0]   pending_s;
    logic [N_SRC-1:0]   eligible_s;
    logic [N_SRC-1:0]   set_s;
    logic [N_SRC-1:0]   clr_s;
    logic [N_SRC-1:0]   claim_onehot_s;
    logic [5:0]         eligible6_s;
    logic [2:0]         id_s;
    logic               valid_s;
    logic               claim_ok_s;
    logic               eoi_wr_s;
    logic               unused_wdata_s;

    // Only the low N_SRC write-data bits carry meaning.
    assign unused_wdata_s = ^wdata;

    // Pending, eligibility, priority selection and claim/clear decode.
    always_comb begin
        pending_s      = (latch_r & EDGE_S) | (src_irq & ~EDGE_S);
        eligible_s     = pending_s & enable_r;
        valid_s        = |eligible_s;
        id_s           = prio_id(eligible_s);
        claim_ok_s     = rd_en && (addr == A_CLAIM) && (state_r == IDLE_ST) && valid_s;
        eoi_wr_s       = wr_en && (addr == A_EOI);
        set_s          = src_irq & ~prev_r & EDGE_S;
        claim_onehot_s = '0;
        if (claim_ok_s) begin
            claim_onehot_s[id_s] = 1'b1;
        end else begin
            claim_onehot_s = '0;
        end
        clr_s = claim_onehot_s;
        if (wr_en && (addr == A_PENDING)) begin
            clr_s = clr_s | wdata[N_SRC-1:0];
        end else begin
            clr_s = claim_onehot_s;
        end
        eligible6_s = 6'd0;
        eligible6_s[N_SRC-1:0] = eligible_s;
    end

    // Outputs to CP0: live eligible set in IDLE, silenced while in service.
    always_comb begin
        busy = (state_r == SERVICE_ST);
        if (state_r == IDLE_ST) begin
            hw_int = eligible6_s;
        end else begin
            hw_int = 6'd0;
        end
    end

    // Register window read mux; reflects pre-write state on simultaneous rd/wr.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_ENABLE:  rdata[N_SRC-1:0] = enable_r;
            A_PENDING: rdata[N_SRC-1:0] = pending_s;
            A_CLAIM: begin
                if ((state_r == IDLE_ST) && valid_s) begin
                    rdata = {1'b1, 28'd0, id_s};
                end else begin
                    rdata = 32'd0;
                end
            end
            A_EOI:     rdata = {29'd0, in_service_id_r};
            default:   rdata = 32'd0;
        endcase
    end

    // ENABLE register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_r <= '0;
        end else if (wr_en && (addr == A_ENABLE)) begin
            enable_r <= wdata[N_SRC-1:0];
        end else begin
            enable_r <= enable_r;
        end
    end

    // Edge detector history and edge latches; a new edge beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r  <= '0;
            latch_r <= '0;
        end else begin
            prev_r  <= src_irq;
            latch_r <= ((latch_r & ~clr_s) | set_s) & EDGE_S;
        end
    end

    // Claim / EOI service FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE_ST;
            in_service_id_r <= 3'd0;
        end else begin
            case (state_r)
                IDLE_ST: begin
                    if (claim_ok_s) begin
                        in_service_id_r <= id_s;
                        state_r         <= SERVICE_ST;
                    end else begin
                        state_r         <= IDLE_ST;
                    end
                end
                SERVICE_ST: begin
                    if (eoi_wr_s) begin
                        state_r <= IDLE_ST;
                    end else begin
                        state_r <= SERVICE_ST;
                    end
                end
                default: begin
                    state_r <= IDLE_ST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed testbench for cp0_int_ctrl with hand-computed expectations.
module tb_cp0_int_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  src_irq;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  hw_int;
    logic        busy;

    int checks_r   = 0;
    int failures_r = 0;
    logic [31:0] v_s;

    cp0_int_ctrl #(.N_SRC(6), .EDGE_MASK(6'b000011)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .hw_int  (hw_int),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
        wr_en = 1'b0; wdata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        rd_en = 1'b1; addr = a;
        #1 v = rdata;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; src_irq = 6'd0; rd_en = 1'b0; wr_en = 1'b0;
        addr = 2'd0; wdata = 32'd0;
        #12;
        chk("rst_hw_int", {26'd0, hw_int}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step();
        chk("init_hw_int", {26'd0, hw_int}, 32'd0);
        chk("init_busy", {31'd0, busy}, 32'd0);
        rd(2'd0, v_s); chk("init_enable", v_s, 32'd0);
        rd(2'd2, v_s); chk("init_claim", v_s, 32'd0);
        chk("init_busy2", {31'd0, busy}, 32'd0);

        // Single edge source claim / EOI
        wr(2'd0, 32'h3F);
        src_irq = 6'b000010; step(); src_irq = 6'd0;
        chk("edge1_hw_int", {26'd0, hw_int}, 32'h2);
        rd(2'd1, v_s); chk("edge1_pending", v_s, 32'h2);
        rd(2'd2, v_s); chk("edge1_claim", v_s, 32'h8000_0001);
        chk("edge1_busy", {31'd0, busy}, 32'd1);
        chk("edge1_hw_int_svc", {26'd0, hw_int}, 32'd0);
        rd(2'd1, v_s); chk("edge1_pending_clr", v_s, 32'd0);
        rd(2'd2, v_s); chk("svc_claim_zero", v_s, 32'd0);
        chk("svc_busy_kept", {31'd0, busy}, 32'd1);
        rd(2'd3, v_s); chk("svc_eoi_id", v_s, 32'd1);
        wr(2'd3, 32'd0);
        chk("eoi_busy", {31'd0, busy}, 32'd0);
        chk("eoi_hw_int", {26'd0, hw_int}, 32'd0);

        // Two simultaneous edges, priority order
        wr(2'd0, 32'h03);
        src_irq = 6'b000011; step(); src_irq = 6'd0;
        chk("dual_hw_int", {26'd0, hw_int}, 32'h3);
        rd(2'd2, v_s); chk("dual_claim0", v_s, 32'h8000_0000);
        chk("dual_hw_int_svc", {26'd0, hw_int}, 32'd0);
        wr(2'd3, 32'd0);
        chk("dual_hw_int_after", {26'd0, hw_int}, 32'h2);
        rd(2'd2, v_s); chk("dual_claim1", v_s, 32'h8000_0001);
        wr(2'd3, 32'd0);
        chk("dual_done", {26'd0, hw_int}, 32'd0);

        // Level source, masked then enabled, W1C ignored
        src_irq = 6'b000100;
        #1 chk("lvl_masked", {26'd0, hw_int}, 32'd0);
        rd(2'd2, v_s); chk("lvl_claim_masked", v_s, 32'd0);
        chk("lvl_busy", {31'd0, busy}, 32'd0);
        wr(2'd0, 32'h07);
        chk("lvl_hw_int", {26'd0, hw_int}, 32'h4);
        wr(2'd1, 32'h4);
        rd(2'd1, v_s); chk("lvl_w1c_ignored", v_s, 32'h4);
        rd(2'd2, v_s); chk("lvl_claim", v_s, 32'h8000_0002);
        src_irq = 6'd0;
        wr(2'd3, 32'd0);

        // Edge and W1C on the same bit in the same cycle: set wins
        src_irq = 6'b000001;
        wr(2'd1, 32'h1);
        src_irq = 6'd0;
        rd(2'd1, v_s); chk("set_wins", v_s, 32'h1);
        chk("set_wins_hw_int", {26'd0, hw_int}, 32'h1);
        wr(2'd1, 32'h1);
        rd(2'd1, v_s); chk("w1c_edge", v_s, 32'd0);

        // Simultaneous read and write of ENABLE returns pre-write value
        rd_en = 1'b1; wr_en = 1'b1; addr = 2'd0; wdata = 32'h3F;
        #1 chk("rdwr_old", rdata, 32'h7);
        step();
        rd_en = 1'b0; wr_en = 1'b0; wdata = 32'd0;
        rd(2'd0, v_s); chk("rdwr_new", v_s, 32'h3F);

        // Reset mid-service
        src_irq = 6'b000010; step(); src_irq = 6'd0;
        rd(2'd2, v_s); chk("rst_svc_claim", v_s, 32'h8000_0001);
        chk("rst_svc_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        addr = 2'd0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hw_int", {26'd0, hw_int}, 32'd0);
        chk("midrst_enable", rdata, 32'd0);
        src_irq = 6'b000001;
        step();
        reset = 1'b1;
        addr = 2'd3;
        #1 chk("post_rst_eoi", rdata, 32'd0);
        step();
        // src_irq[0] held high across release counts as an edge on the first clock
        rd(2'd1, v_s); chk("post_rst_edge", v_s, 32'h1);
        chk("post_rst_hw_int", {26'd0, hw_int}, 32'd0);
        src_irq = 6'd0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
